dlatch_bank_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared W-bit bank of dlatch cells.

---
 rtl/dlatch_bank_arbiter_if.sv | 25 ++
 rtl/dlatch_bank_arbiter.sv | 138 +++++++++++++
 tb/tb_dlatch_bank_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dlatch_bank_arbiter_if.sv
// Requester, bank and status signals between the arbiter (slave) and its environment (master).
interface dlatch_bank_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   latch_Q;
  logic           latch_En;
  logic [W-1:0]   latch_D;
  logic           busy;
  logic           err;

  modport master (
    output req, req_data, latch_Q,
    input  gnt, ack, latch_En, latch_D, busy, err
  );

  modport slave (
    input  req, req_data, latch_Q,
    output gnt, ack, latch_En, latch_D, busy, err
  );
endinterface

// File: rtl/dlatch_bank_arbiter.sv
// Round-robin writer for a shared dlatch bank: setup -> enable -> hold -> ack, grant-to-ack 2+EN_CYCLES cycles.
// Requesters hold req until ack; req is only sampled in IDLE, so a busy bank simply defers everyone.
module dlatch_bank_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dlatch_bank_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EN_CYCLES - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            latch_en_q, latch_en_d;
  logic [W-1:0]    latch_d_q, latch_d_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [IW-1:0]   pick;
  logic            found;

  // First requester at or after rr_ptr, wrapping mod N.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[(int'(rr_ptr_q) + k) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    latch_en_d = latch_en_q;
    latch_d_d  = latch_d_q;
    busy_d     = busy_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_SETUP;
          winner_d  = pick;
          gnt_d     = ONE_HOT0 << pick;
          latch_d_d = bus.req_data[int'(pick)*W +: W];
          busy_d    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d    = S_ENABLE;
        latch_en_d = 1'b1;
        cnt_d      = '0;
      end
      S_ENABLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_HOLD;
          latch_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.latch_Q != latch_d_q) begin
          err_d = 1'b1;
        end
        state_d = S_ACK;
        ack_d   = gnt_q;
      end
      S_ACK: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (winner_q == IW'(N - 1)) ? '0 : winner_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset lands on an edge, so a write in flight drops En immediately and never acks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      winner_q   <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      latch_en_q <= latch_en_d;
      latch_d_q  <= latch_d_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.latch_En = latch_en_q;
  assign bus.latch_D  = latch_d_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_dlatch_bank_arbiter.sv
// Directed bench for dlatch_bank_arbiter with a behavioural dlatch bank on latch_En/latch_D.
module tb_dlatch_bank_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EN = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlatch_bank_arbiter_if #(.N(N), .W(W)) bus ();

  dlatch_bank_arbiter #(.N(N), .W(W), .EN_CYCLES(EN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [W-1:0] bank_q;
  logic         force_bad = 1'b0;
  logic [W-1:0] bad_val   = '0;

  always_latch begin
    if (bus.latch_En) bank_q <= bus.latch_D;
  end
  assign bus.latch_Q = force_bad ? bad_val : bank_q;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  // Steps until ack is seen or the budget runs out (then a stays 0 and the caller's check fails).
  task automatic wait_ack(output logic [N-1:0] a, output int n);
    a = '0;
    n = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      n++;
      if (bus.ack != '0) begin
        a = bus.ack;
        break;
      end
    end
  endtask

  logic [N-1:0] a;
  int           n;
  logic [N-1:0] exp_seq [5];

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    exp_seq      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_en",   bus.latch_En, 0);
    chk("rst_d",    bus.latch_D,  0);
    chk("rst_gnt",  bus.gnt,      0);
    chk("rst_ack",  bus.ack,      0);
    chk("rst_busy", bus.busy,     0);
    chk("rst_err",  bus.err,      0);
    rst_n = 1'b1;

    // Single write from requester 2, cycle by cycle
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'hA5);
    set_data(3, 8'h44);
    bus.req = 4'b0100;
    step();
    chk("t2_gnt",      bus.gnt,      4'b0100);
    chk("t2_d",        bus.latch_D,  8'hA5);
    chk("t2_busy",     bus.busy,     1);
    chk("t2_setup_en", bus.latch_En, 0);
    step();
    chk("t2_en1",      bus.latch_En, 1);
    chk("t2_en1_gnt",  bus.gnt,      4'b0100);
    step();
    chk("t2_en2",      bus.latch_En, 1);
    chk("t2_en2_d",    bus.latch_D,  8'hA5);
    step();
    chk("t2_hold_en",  bus.latch_En, 0);
    chk("t2_hold_ack", bus.ack,      0);
    step();
    chk("t2_ack",      bus.ack,      4'b0100);
    chk("t2_ack_busy", bus.busy,     1);
    chk("t2_ack_gnt",  bus.gnt,      4'b0100);
    bus.req = '0;
    step();
    chk("t2_idle_ack",  bus.ack,     0);
    chk("t2_idle_gnt",  bus.gnt,     0);
    chk("t2_idle_busy", bus.busy,    0);
    chk("t2_bank",      bus.latch_Q, 8'hA5);
    chk("t2_err",       bus.err,     0);

    // Reset in the middle of ENABLE
    bus.req = 4'b0001;
    step();
    step();
    chk("t1_pre_en", bus.latch_En, 1);
    rst_n   = 1'b0;
    bus.req = '0;
    step();
    chk("t1_en",   bus.latch_En, 0);
    chk("t1_gnt",  bus.gnt,      0);
    chk("t1_busy", bus.busy,     0);
    chk("t1_ack",  bus.ack,      0);
    step();
    chk("t1_ack2", bus.ack,      0);
    rst_n = 1'b1;
    step();
    chk("t1_post_busy", bus.busy, 0);
    chk("t1_post_ack",  bus.ack,  0);

    // All requesting: 0,1,2,3,0 with one idle cycle between writes
    set_data(0, 8'hC1);
    set_data(1, 8'hC2);
    set_data(2, 8'hC3);
    set_data(3, 8'hC4);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(a, n);
      chk("t3_ack", a,       exp_seq[g]);
      chk("t3_gnt", bus.gnt, exp_seq[g]);
      chk("t3_lat", n,       5);
      if (g == 4) bus.req = '0;
      step();
      chk("t3_pulse", bus.ack,  0);
      chk("t3_gap",   bus.busy, 0);
    end
    chk("t3_bank", bus.latch_Q, 8'hC1);

    // Move rr_ptr to 2, then requesters 1 and 3: 3 goes first
    set_data(1, 8'h77);
    bus.req = 4'b0010;
    wait_ack(a, n);
    chk("t4_pre_ack", a, 4'b0010);
    bus.req = '0;
    step();
    set_data(1, 8'h66);
    set_data(3, 8'h99);
    bus.req = 4'b1010;
    wait_ack(a, n);
    chk("t4_first",  a,           4'b1000);
    chk("t4_bank3",  bus.latch_Q, 8'h99);
    bus.req = 4'b0010;
    step();
    wait_ack(a, n);
    chk("t4_second", a,           4'b0010);
    chk("t4_bank1",  bus.latch_Q, 8'h66);
    bus.req = '0;
    step();

    // Readback mismatch during HOLD sets a sticky error
    chk("t5_err_pre", bus.err, 0);
    set_data(0, 8'h3C);
    force_bad = 1'b1;
    bad_val   = 8'h00;
    bus.req   = 4'b0001;
    wait_ack(a, n);
    chk("t5_ack", a,       4'b0001);
    chk("t5_err", bus.err, 1);
    bus.req   = '0;
    force_bad = 1'b0;
    step();
    chk("t5_err_idle", bus.err, 1);
    bus.req = 4'b0001;
    wait_ack(a, n);
    chk("t5_ack2", a, 4'b0001);
    bus.req = '0;
    step();
    chk("t5_sticky", bus.err, 1);
    rst_n = 1'b0;
    step();
    chk("t5_err_rst", bus.err, 0);
    rst_n = 1'b1;

    // Request withdrawn during ENABLE: the write still completes and acks
    set_data(0, 8'h5A);
    bus.req = 4'b0001;
    step();
    chk("t6_gnt", bus.gnt, 4'b0001);
    step();
    chk("t6_en", bus.latch_En, 1);
    bus.req = '0;
    wait_ack(a, n);
    chk("t6_ack",   a, 4'b0001);
    chk("t6_lat",   n, 3);
    step();
    chk("t6_bank",  bus.latch_Q, 8'h5A);
    chk("t6_gnt0",  bus.gnt,     0);
    step();
    step();
    chk("t6_no_regrant", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
